skid_buffer_reg: RTL and testbench

- Registered valid/ready pipeline slice built from edge-triggered flip-flops only; no latches.
- Sits directly downstream of a data-producing flip-flop stage.
- Decouples producer and consumer timing: every output is driven from a register, including the upstream ready.
- Sustains one transfer per clock, with a single-entry skid register that absorbs a consumer stall without dropping data.

---
 rtl/skid_pkg.sv | 21 ++
 rtl/skid_buffer_reg.sv | 89 ++++++++
 tb/tb_skid_buffer_reg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/skid_pkg.sv
// Shared types for the registered skid-buffer slice: state encoding and occupancy width.
package skid_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Words held in each state; an unknown encoding reads as empty.
  function automatic logic [OCC_W-1:0] occOf(input state_t s);
    case (s)
      BUSY:    occOf = 2'd1;
      FULL:    occOf = 2'd2;
      default: occOf = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_reg.sv
// Registered valid/ready slice with a one-word skid register; every output comes straight from a flop.
module skid_buffer_reg
  import skid_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [OCC_W-1:0]      occupancy
);

  state_t                state;
  state_t                stateNext;
  logic [DATA_WIDTH-1:0] skidData;
  logic                  inXfer;
  logic                  outXfer;
  logic                  loadMain;
  logic                  mainFromSkid;
  logic                  loadSkid;

  assign inXfer  = s_valid & s_ready;
  assign outXfer = m_valid & m_ready;

  always_comb begin
    stateNext    = state;
    loadMain     = 1'b0;
    mainFromSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state)
      EMPTY: begin
        if (inXfer) begin
          stateNext = BUSY;
          loadMain  = 1'b1;
        end
      end
      BUSY: begin
        case ({inXfer, outXfer})
          2'b11: loadMain = 1'b1;
          2'b10: begin
            loadSkid  = 1'b1;
            stateNext = FULL;
          end
          2'b01: stateNext = EMPTY;
          default: stateNext = BUSY;
        endcase
      end
      FULL: begin
        if (outXfer) begin
          loadMain     = 1'b1;
          mainFromSkid = 1'b1;
          stateNext    = BUSY;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  // Status flags are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      m_valid   <= 1'b0;
      s_ready   <= 1'b1;
      occupancy <= '0;
    end else begin
      state     <= stateNext;
      m_valid   <= (stateNext != EMPTY);
      s_ready   <= (stateNext != FULL);
      occupancy <= occOf(stateNext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data   <= '0;
      skidData <= '0;
    end else begin
      if (loadMain) m_data <= mainFromSkid ? skidData : s_data;
      if (loadSkid) skidData <= s_data;
    end
  end

endmodule

// File: tb/tb_skid_buffer_reg.sv
// Self-checking bench: queue model of a two-deep FIFO slice plus directed literal checks.
module tb_skid_buffer_reg;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  int errors = 0;
  int checks = 0;

  logic [7:0] modelQ[$];
  bit         inAcc;
  bit         outAcc;

  bit compareOn  = 0;
  bit bubbleOn   = 0;
  int acceptCnt  = 0;
  int deliverCnt = 0;

  skid_buffer_reg #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .occupancy(occupancy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge consume them, return just after it.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(posedge clk);
    #2;
  endtask

  // Two-deep FIFO: accept while fewer than two held, deliver while any held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
    end else begin
      inAcc  = s_valid && (modelQ.size() < 2);
      outAcc = (modelQ.size() > 0) && m_ready;
      if (outAcc) void'(modelQ.pop_front());
      if (inAcc) modelQ.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    if (compareOn && !rst) begin
      checkOutput("model m_valid", {31'd0, m_valid}, {31'd0, modelQ.size() > 0});
      checkOutput("model s_ready", {31'd0, s_ready}, {31'd0, modelQ.size() < 2});
      checkOutput("model occupancy", {30'd0, occupancy}, modelQ.size());
      if (modelQ.size() > 0) checkOutput("model m_data", {24'd0, m_data}, {24'd0, modelQ[0]});
    end
    if (bubbleOn && !rst) begin
      checkOutput("bubble occupancy", {30'd0, occupancy}, acceptCnt - deliverCnt);
      if (m_valid && m_ready) begin
        checkOutput("bubble order", {24'd0, m_data}, {24'd0, deliverCnt[7:0]});
        deliverCnt++;
      end
    end
  end

  initial begin
    bit v;
    bit r;
    bit willAccept;
    rst     = 1;
    s_valid = 0;
    s_data  = 0;
    m_ready = 0;
    #23;
    checkOutput("reset m_valid", {31'd0, m_valid}, 0);
    checkOutput("reset s_ready", {31'd0, s_ready}, 1);
    checkOutput("reset occupancy", {30'd0, occupancy}, 0);
    checkOutput("reset m_data", {24'd0, m_data}, 0);
    rst = 0;
    @(posedge clk);
    #2;
    compareOn = 1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, i[7:0], 1);
      checkOutput("stream m_data", {24'd0, m_data}, i);
      checkOutput("stream occupancy", {30'd0, occupancy}, 1);
      checkOutput("stream s_ready", {31'd0, s_ready}, 1);
    end
    applyStimulus(0, 8'h00, 1);
    checkOutput("drain occupancy", {30'd0, occupancy}, 0);

    applyStimulus(1, 8'h20, 0);
    applyStimulus(1, 8'h21, 1);
    checkOutput("simul m_data", {24'd0, m_data}, 32'h21);
    checkOutput("simul occupancy", {30'd0, occupancy}, 1);
    applyStimulus(0, 8'h00, 1);

    applyStimulus(1, 8'h10, 0);
    checkOutput("busy m_data", {24'd0, m_data}, 32'h10);
    applyStimulus(1, 8'h11, 0);
    checkOutput("stall s_ready", {31'd0, s_ready}, 0);
    checkOutput("stall occupancy", {30'd0, occupancy}, 2);
    checkOutput("stall m_data", {24'd0, m_data}, 32'h10);
    applyStimulus(1, 8'h55, 0);
    checkOutput("hold m_data", {24'd0, m_data}, 32'h10);
    checkOutput("hold m_valid", {31'd0, m_valid}, 1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("release m_data", {24'd0, m_data}, 32'h11);
    checkOutput("release s_ready", {31'd0, s_ready}, 1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("release drain", {30'd0, occupancy}, 0);

    applyStimulus(1, 8'hA1, 0);
    applyStimulus(1, 8'hA2, 0);
    checkOutput("pre-reset occupancy", {30'd0, occupancy}, 2);
    #1;
    rst = 1;
    #1;
    checkOutput("async m_valid", {31'd0, m_valid}, 0);
    checkOutput("async s_ready", {31'd0, s_ready}, 1);
    checkOutput("async occupancy", {30'd0, occupancy}, 0);
    @(posedge clk);
    #3;
    rst = 0;
    @(posedge clk);
    #2;
    applyStimulus(1, 8'h33, 1);
    checkOutput("post-reset m_data", {24'd0, m_data}, 32'h33);
    checkOutput("post-reset m_valid", {31'd0, m_valid}, 1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("post-reset drain", {30'd0, occupancy}, 0);

    acceptCnt  = 0;
    deliverCnt = 0;
    bubbleOn   = 1;
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      willAccept = v && (modelQ.size() < 2);
      applyStimulus(v, acceptCnt[7:0], r);
      if (willAccept) acceptCnt++;
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1);
    bubbleOn = 0;
    checkOutput("bubble delivered all", deliverCnt, acceptCnt);

    compareOn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
